// File: rtl/irq_ctrl.sv
// irq_ctrl -- interrupt controller sitting behind the timer and the other
// bus devices. Device irq lines are latched into pending bits (edge or
// level mode per source), qualified by a per-source mask and a global
// enable, and the highest-priority one (lowest index) is presented to the
// CPU. A request/acknowledge/end-of-interrupt handshake follows.
//
// Ports:
//   clk      system clock, all state changes on its rising edge
//   rst      asynchronous active-low reset (0 = reset)
//   addr     register select: 00 MASK, 01 PEND, 10 ID/EOI, 11 MODE
//   we       write enable (level, sampled at posedge clk)
//   data_in  write data
//   data_out combinational read data of the addressed register
//   irq_in   device interrupt lines, bit 0 is the timer
//   cpu_irq  registered interrupt request to the CPU
//   irq_id   registered id of the requested / in-service source
//   cpu_ack  one-cycle CPU acknowledge of cpu_irq
module irq_ctrl #(
  parameter int NUM_SRC = 6,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:2]         addr,
  input  logic               we,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    irq_id,
  input  logic               cpu_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_SRC-1:0] mask_en;
  logic               gie;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] irq_prev;

  logic [NUM_SRC-1:0] active;
  logic [ID_W-1:0]    best;
  logic [NUM_SRC-1:0] id_onehot;
  logic               id_active;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] w1c_vec;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] pend_next;
  logic               cpu_irq_next;
  logic [ID_W-1:0]    irq_id_next;
  logic               in_service;
  logic               mask_wr, pend_wr, eoi, mode_wr;

  // Register bits beyond the implemented sources carry no state.
  logic unused_data;
  assign unused_data = ^data_in[30:NUM_SRC];

  assign mask_wr    = we && (addr == 2'b00);
  assign pend_wr    = we && (addr == 2'b01);
  assign eoi        = we && (addr == 2'b10);
  assign mode_wr    = we && (addr == 2'b11);
  assign in_service = (state == SERVICE);

  assign active = gie ? (pend & mask_en) : '0;

  // Edge-mode sources set on a rising line, level-mode sources set every
  // cycle the line is high. Setting beats both W1C and the ack clear so a
  // fresh event is never lost.
  assign set_vec   = (mode & irq_in & ~irq_prev) | (~mode & irq_in);
  assign w1c_vec   = pend_wr ? data_in[NUM_SRC-1:0] : '0;
  assign ack_clr   = ((state == REQ) && cpu_ack) ? (id_onehot & mode) : '0;
  assign pend_next = (pend & ~w1c_vec & ~ack_clr) | set_vec;

  // Fixed priority: scanning downward leaves the lowest active index.
  always_comb begin
    best = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) best = ID_W'(i);
    end
  end

  // Decode irq_id into a source vector without an out-of-range bit select.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (irq_id == ID_W'(i)) id_onehot[i] = 1'b1;
    end
  end

  assign id_active = |(id_onehot & active);

  always_comb begin
    data_out = '0;
    case (addr)
      2'b00: begin
        data_out[31]          = gie;
        data_out[NUM_SRC-1:0] = mask_en;
      end
      2'b01: data_out[NUM_SRC-1:0] = pend;
      2'b10: begin
        data_out[31]       = in_service;
        data_out[ID_W-1:0] = irq_id;
      end
      default: data_out[NUM_SRC-1:0] = mode;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_en  <= '0;
      gie      <= 1'b0;
      mode     <= '0;
      pend     <= '0;
      irq_prev <= '0;
    end else begin
      if (mask_wr) begin
        mask_en <= data_in[NUM_SRC-1:0];
        gie     <= data_in[31];
      end
      if (mode_wr) mode <= data_in[NUM_SRC-1:0];
      pend     <= pend_next;
      irq_prev <= irq_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cpu_irq <= 1'b0;
      irq_id  <= '0;
    end else begin
      state   <= state_next;
      cpu_irq <= cpu_irq_next;
      irq_id  <= irq_id_next;
    end
  end

  // A request is withdrawn if its source stops being active before the
  // ack; an ack in the same cycle takes precedence. No preemption or
  // nesting: irq_id only changes when leaving IDLE.
  always_comb begin
    state_next   = state;
    cpu_irq_next = cpu_irq;
    irq_id_next  = irq_id;
    case (state)
      IDLE: begin
        if (|active) begin
          irq_id_next  = best;
          cpu_irq_next = 1'b1;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (cpu_ack) begin
          cpu_irq_next = 1'b0;
          state_next   = SERVICE;
        end else if (!id_active) begin
          cpu_irq_next = 1'b0;
          state_next   = IDLE;
        end
      end
      SERVICE: begin
        cpu_irq_next = 1'b0;
        if (eoi) state_next = IDLE;
      end
      default: begin
        cpu_irq_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl -- directed bench for irq_ctrl. Inputs are driven and
// outputs sampled at the falling clock edge, away from the active edge.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:2]  addr;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [5:0]  irq_in;
  logic        cpu_irq;
  logic [2:0]  irq_id;
  logic        cpu_ack;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.NUM_SRC(6), .ID_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .irq_in   (irq_in),
    .cpu_irq  (cpu_irq),
    .irq_id   (irq_id),
    .cpu_ack  (cpu_ack)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    addr    = a;
    data_in = d;
    we      = 1'b1;
    tick();
    we      = 1'b0;
    data_in = '0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a,
                           input logic [31:0] expected);
    addr = a;
    #1;
    check_output(tag, data_out, expected);
  endtask

  task automatic pulse_ack();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    addr    = 2'b00;
    we      = 1'b0;
    data_in = '0;
    irq_in  = '0;
    cpu_ack = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Reset state
    check_output("reset_cpu_irq", {31'd0, cpu_irq}, 32'd0);
    check_output("reset_irq_id", {29'd0, irq_id}, 32'd0);
    check_reg("reset_mask", 2'b00, 32'h0);
    check_reg("reset_pend", 2'b01, 32'h0);
    check_reg("reset_mode", 2'b11, 32'h0);
    check_reg("reset_id", 2'b10, 32'h0);

    // Basic level-mode request on source 0
    write_reg(2'b00, 32'h8000_0001);
    write_reg(2'b11, 32'h0000_0000);
    check_reg("mask_rb", 2'b00, 32'h8000_0001);
    irq_in = 6'h01;
    tick();
    check_reg("basic_pend_e0", 2'b01, 32'h1);
    check_output("basic_noirq_e0", {31'd0, cpu_irq}, 32'd0);
    tick();
    check_output("basic_irq_e1", {31'd0, cpu_irq}, 32'd1);
    check_output("basic_id_e1", {29'd0, irq_id}, 32'd0);
    tick();
    irq_in = 6'h00;
    pulse_ack();
    check_output("basic_ack_drop", {31'd0, cpu_irq}, 32'd0);
    check_reg("basic_id_inserv", 2'b10, 32'h8000_0000);
    check_reg("basic_level_pend", 2'b01, 32'h1);
    write_reg(2'b01, 32'h1);
    check_reg("basic_w1c", 2'b01, 32'h0);
    write_reg(2'b10, 32'h0);
    check_reg("basic_eoi_id", 2'b10, 32'h0);
    tick();
    check_output("basic_idle_noirq", {31'd0, cpu_irq}, 32'd0);

    // Priority among simultaneous edge sources 1, 2, 5
    write_reg(2'b00, 32'h8000_0026);
    write_reg(2'b11, 32'h0000_003F);
    irq_in = 6'b100110;
    tick();
    irq_in = 6'h00;
    check_reg("prio_pend", 2'b01, 32'h26);
    tick();
    check_output("prio_irq1", {31'd0, cpu_irq}, 32'd1);
    check_output("prio_id1", {29'd0, irq_id}, 32'd1);
    pulse_ack();
    check_reg("prio_pend_after1", 2'b01, 32'h24);
    write_reg(2'b10, 32'h0);
    tick();
    check_output("prio_id2", {29'd0, irq_id}, 32'd2);
    pulse_ack();
    write_reg(2'b10, 32'h0);
    tick();
    check_output("prio_irq5", {31'd0, cpu_irq}, 32'd1);
    check_output("prio_id5", {29'd0, irq_id}, 32'd5);
    pulse_ack();
    write_reg(2'b10, 32'h0);
    check_reg("prio_pend_end", 2'b01, 32'h0);
    check_output("prio_idle", {31'd0, cpu_irq}, 32'd0);

    // Edge vs level with continuous W1C
    write_reg(2'b00, 32'h0000_0000);
    write_reg(2'b11, 32'h0000_0002);
    addr    = 2'b01;
    data_in = 32'h6;
    we      = 1'b1;
    irq_in  = 6'b000110;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("edge_level_pend", data_out, (i == 0) ? 32'h6 : 32'h4);
    end
    irq_in = 6'h00;
    tick();
    we      = 1'b0;
    data_in = '0;
    check_reg("edge_level_clear", 2'b01, 32'h0);

    // Withdrawal of a source-3 request by masking
    write_reg(2'b11, 32'h0000_0008);
    write_reg(2'b00, 32'h8000_0008);
    irq_in = 6'h08;
    tick();
    irq_in = 6'h00;
    tick();
    check_output("wd_irq", {31'd0, cpu_irq}, 32'd1);
    check_output("wd_id", {29'd0, irq_id}, 32'd3);
    write_reg(2'b00, 32'h8000_0000);
    check_output("wd_still_req", {31'd0, cpu_irq}, 32'd1);
    tick();
    check_output("wd_dropped", {31'd0, cpu_irq}, 32'd0);
    pulse_ack();
    check_output("wd_ack_ignored", {31'd0, cpu_irq}, 32'd0);
    check_reg("wd_not_inserv", 2'b10, 32'h3);
    check_reg("wd_pend_kept", 2'b01, 32'h8);
    write_reg(2'b01, 32'h8);

    // GIE gating
    write_reg(2'b11, 32'h0000_0010);
    write_reg(2'b00, 32'h0000_0010);
    irq_in = 6'h10;
    tick();
    irq_in = 6'h00;
    tick();
    tick();
    check_reg("gie_pend", 2'b01, 32'h10);
    check_output("gie_off_noirq", {31'd0, cpu_irq}, 32'd0);
    write_reg(2'b00, 32'h8000_0010);
    check_output("gie_on_edge0", {31'd0, cpu_irq}, 32'd0);
    tick();
    check_output("gie_on_irq", {31'd0, cpu_irq}, 32'd1);
    check_output("gie_on_id", {29'd0, irq_id}, 32'd4);

    // Asynchronous reset while in REQ
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_irq", {31'd0, cpu_irq}, 32'd0);
    check_output("arst_id", {29'd0, irq_id}, 32'd0);
    tick();
    rst = 1'b1;
    check_reg("arst_mask", 2'b00, 32'h0);
    check_reg("arst_pend", 2'b01, 32'h0);
    check_reg("arst_mode", 2'b11, 32'h0);
    write_reg(2'b10, 32'h0);
    pulse_ack();
    tick();
    check_output("arst_idle_irq", {31'd0, cpu_irq}, 32'd0);
    check_reg("arst_idle_id", 2'b10, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
